hls_run_sequencer: RTL and testbench
====================================

HLS_RUN_SEQUENCER -- requirements
Module: hls_run_sequencer

Interface
REQ-001 The block SHALL have parameter CH_ADDR_W, default 7, meaning per-channel slave address width.
REQ-002 The block SHALL have parameter CH_DATA_W, default 8, meaning per-channel slave data width.
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning run-cycle counter width.
REQ-004 The block SHALL have parameter RUN_TIMEOUT, default 200000000, meaning run abort limit in cycles.
REQ-005 The block SHALL have parameter MEM_TIMEOUT, default 256, meaning slave-access abort limit in cycles.
REQ-006 The block SHALL have one clock, named clock; reset is asynchronous and active-low, named reset.
REQ-007 The block SHALL have these ports, clock and reset first:
- clock  in  1  system clock
- reset  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  0=WRITE byte, 1=READ byte, 2=RUN, 3=reserved
- cmd_addr  in  CH_ADDR_W  byte address
- cmd_wdata  in  CH_DATA_W  write byte
- rsp_valid  out  1  response pending
- rsp_ready  in  1  response consumed
- rsp_rdata  out  CH_DATA_W  read byte, else 0
- rsp_status  out  2  0=OK, 1=MEM_TIMEOUT, 2=RUN_TIMEOUT, 3=BAD_OP
- run_cycles  out  CNT_W  cycle count of last RUN
- busy  out  1  high in every state except IDLE
- start_port  out  1  accelerator start pulse
- done_port  in  1  accelerator done
- S_oe_ram  out  2  slave read enables
- S_we_ram  out  2  slave write enables
- S_addr_ram  out  2*CH_ADDR_W  slave addresses
- S_Wdata_ram  out  2*CH_DATA_W  slave write data
- S_data_ram_size  out  8  slave access sizes, 4 bits/channel
- Sout_Rdata_ram  in  2*CH_DATA_W  slave read data
- Sout_DataRdy  in  2  slave access complete

Function
REQ-008 The FSM SHALL have states IDLE, MEM_REQ, MEM_WAIT, START, RUN, RESP.
REQ-009 cmd_ready SHALL be high only in IDLE; acceptance latches op/addr/wdata.
REQ-010 From IDLE, accepted WRITE/READ SHALL go to MEM_REQ, RUN to START, op 3 to RESP with BAD_OP.
REQ-011 In MEM_REQ, for exactly one cycle, channel 0 SHALL drive we[0]=1 (WRITE) or oe[0]=1 (READ), the address, the data and size 4'd8; channel 1 and all other cycles SHALL drive 0.
REQ-012 In MEM_WAIT, Sout_DataRdy[0]=1 SHALL go to RESP with OK, capturing Sout_Rdata_ram[CH_DATA_W-1:0] for READ and 0 for WRITE.
REQ-013 A DataRdy already high in MEM_REQ SHALL be accepted in that cycle, going directly to RESP.
REQ-014 MEM_WAIT lasting MEM_TIMEOUT cycles without DataRdy SHALL go to RESP with MEM_TIMEOUT.
REQ-015 START SHALL last one cycle with start_port=1 and counter set to 1; then go to RUN.
REQ-016 RUN SHALL increment the counter each cycle; done_port=1 sampled in RUN SHALL load run_cycles with the counter+1 and go to RESP with OK; done_port in START is ignored.
- Minimum run_cycles SHALL be 2 (done in the cycle after start).
REQ-017 The counter SHALL saturate at all-ones and never wrap.
REQ-018 In RESP, rsp_valid SHALL be 1 and hold its data stable until rsp_ready; handshake returns to IDLE the next cycle.
REQ-019 run_cycles SHALL hold its value until the next RUN completes or times out.

Reset
REQ-020 reset low SHALL asynchronously force IDLE, all outputs 0 except cmd_ready=1 once released, counter 0.
REQ-021 Reset asserted mid-RUN or mid-MEM_WAIT SHALL abort with no response issued.

Configuration
REQ-022 With HLS_RUN_TIMEOUT_EN defined, RUN reaching RUN_TIMEOUT cycles SHALL go to RESP with RUN_TIMEOUT and run_cycles=RUN_TIMEOUT.
REQ-023 Without HLS_RUN_TIMEOUT_EN, RUN SHALL wait indefinitely and RUN_TIMEOUT is unused.

Structure
REQ-024 Package hls_run_pkg SHALL hold the op encodings, status encodings, state enum and size constant 4'd8.
REQ-025 The saturating counter SHALL be sub-module hls_cycle_counter (clear, load-1, increment, saturate).

Verification
REQ-026 WRITE addr 0x05 data 0xA5, DataRdy two cycles after we -> we[0] one cycle, S_addr_ram[6:0]=0x05, rsp OK.
REQ-027 READ addr 0x05, DataRdy with Sout_Rdata_ram[7:0]=0x3C -> rsp_rdata=0x3C, status OK.
REQ-028 RUN, done_port high 10 cycles after start pulse -> run_cycles=11, status OK, start_port high exactly one cycle.
REQ-029 READ with DataRdy never asserted -> rsp after 256 wait cycles, status MEM_TIMEOUT.
REQ-030 With HLS_RUN_TIMEOUT_EN and RUN_TIMEOUT=50, done never high -> status RUN_TIMEOUT, run_cycles=50.
REQ-031 reset low in RUN, then RUN with rsp_ready held low 5 cycles -> no response from aborted run; second response held stable, then IDLE.

Source files
------------

// File: rtl/hls_run_pkg.sv
// hls_run_pkg: command/status encodings, FSM states and access size shared by the run sequencer.
package hls_run_pkg;
   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_RUN   = 2'd2;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   localparam logic [1:0] ST_OK       = 2'd0;
   localparam logic [1:0] ST_MEM_TO   = 2'd1;
   localparam logic [1:0] ST_RUN_TO   = 2'd2;
   localparam logic [1:0] ST_BAD_OP   = 2'd3;

   localparam logic [3:0] SIZE_BYTE = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE, S_MEM_REQ, S_MEM_WAIT, S_START, S_RUN, S_RESP
   } state_e;
endpackage

// File: rtl/hls_cycle_counter.sv
// hls_cycle_counter: saturating cycle counter with clear, load-one and increment.
module hls_cycle_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             load1_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic [CNT_W-1:0] cnt_inc_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Sticks at all-ones rather than wrapping back to zero.
   assign cnt_inc_o = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
   assign cnt_o     = cnt_q;

   always_comb cnt_d = clr_i ? '0 : load1_i ? CNT_W'(1) : inc_i ? cnt_inc_o : cnt_q;

   always_ff @(posedge clock or negedge reset)
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
endmodule

// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer: byte access to slave channel 0 and timed accelerator runs behind a cmd/rsp handshake.
// Define HLS_RUN_TIMEOUT_EN to abort runs that reach RUN_TIMEOUT cycles.
module hls_run_sequencer
   import hls_run_pkg::*;
#(
   parameter int CH_ADDR_W   = 7,
   parameter int CH_DATA_W   = 8,
   parameter int CNT_W       = 32,
   parameter int RUN_TIMEOUT = 200000000,
   parameter int MEM_TIMEOUT = 256
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [CH_ADDR_W-1:0]   cmd_addr,
   input  logic [CH_DATA_W-1:0]   cmd_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [CH_DATA_W-1:0]   rsp_rdata,
   output logic [1:0]             rsp_status,
   output logic [CNT_W-1:0]       run_cycles,
   output logic                   busy,
   output logic                   start_port,
   input  logic                   done_port,
   output logic [1:0]             S_oe_ram,
   output logic [1:0]             S_we_ram,
   output logic [2*CH_ADDR_W-1:0] S_addr_ram,
   output logic [2*CH_DATA_W-1:0] S_Wdata_ram,
   output logic [7:0]             S_data_ram_size,
   input  logic [2*CH_DATA_W-1:0] Sout_Rdata_ram,
   input  logic [1:0]             Sout_DataRdy
);
`ifdef HLS_RUN_TIMEOUT_EN
   localparam bit RUN_TO_EN = 1'b1;
`else
   localparam bit RUN_TO_EN = 1'b0;
`endif
   localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(RUN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] MEM_LIM = CNT_W'(MEM_TIMEOUT - 1);

   state_e                 state_q, state_d;
   logic [1:0]             op_q, op_d, status_q, status_d;
   logic [CH_ADDR_W-1:0]   addr_q, addr_d, addr0;
   logic [CH_DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d, wdata0;
   logic [CNT_W-1:0]       runc_q, runc_d, cnt, cnt_inc;
   logic                   mem_req, run_to, unused_ok;

   hls_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .clr_i     (state_q == S_MEM_REQ),
      .load1_i   (state_q == S_START),
      .inc_i     (state_q == S_RUN || state_q == S_MEM_WAIT),
      .cnt_o     (cnt),
      .cnt_inc_o (cnt_inc)
   );

   // cnt is k in the k-th RUN cycle, so the elapsed run length including START is cnt+1.
   assign run_to  = RUN_TO_EN && (cnt >= RUN_LIM);
   assign mem_req = state_q == S_MEM_REQ;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      status_d = status_q;
      runc_d   = runc_q;
      case (state_q)
         S_IDLE:
            if (cmd_valid) begin
               op_d     = cmd_op;
               addr_d   = cmd_addr;
               wdata_d  = cmd_wdata;
               rdata_d  = '0;
               status_d = (cmd_op == OP_RSVD) ? ST_BAD_OP : ST_OK;
               state_d  = (cmd_op == OP_RUN) ? S_START : (cmd_op == OP_RSVD) ? S_RESP : S_MEM_REQ;
            end
         S_MEM_REQ, S_MEM_WAIT:
            if (Sout_DataRdy[0]) begin
               state_d = S_RESP;
               rdata_d = (op_q == OP_READ) ? Sout_Rdata_ram[CH_DATA_W-1:0] : '0;
            end else if (state_q == S_MEM_WAIT && cnt == MEM_LIM) begin
               state_d  = S_RESP;
               status_d = ST_MEM_TO;
            end else begin
               state_d = S_MEM_WAIT;
            end
         S_START: state_d = S_RUN;
         S_RUN:
            if (done_port) begin
               state_d = S_RESP;
               runc_d  = cnt_inc;
            end else if (run_to) begin
               state_d  = S_RESP;
               status_d = ST_RUN_TO;
               runc_d   = CNT_W'(RUN_TIMEOUT);
            end
         S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         status_q <= '0;
         runc_q   <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         status_q <= status_d;
         runc_q   <= runc_d;
      end

   assign addr0           = mem_req ? addr_q : '0;
   assign wdata0          = mem_req ? wdata_q : '0;
   assign cmd_ready       = state_q == S_IDLE;
   assign busy            = state_q != S_IDLE;
   assign start_port      = state_q == S_START;
   assign rsp_valid       = state_q == S_RESP;
   assign rsp_rdata       = rsp_valid ? rdata_q : '0;
   assign rsp_status      = rsp_valid ? status_q : '0;
   assign run_cycles      = runc_q;
   assign S_we_ram        = {1'b0, mem_req && op_q == OP_WRITE};
   assign S_oe_ram        = {1'b0, mem_req && op_q == OP_READ};
   assign S_addr_ram      = {{CH_ADDR_W{1'b0}}, addr0};
   assign S_Wdata_ram     = {{CH_DATA_W{1'b0}}, wdata0};
   assign S_data_ram_size = {4'd0, mem_req ? SIZE_BYTE : 4'd0};
   assign unused_ok       = ^{Sout_Rdata_ram[2*CH_DATA_W-1:CH_DATA_W], Sout_DataRdy[1]};
endmodule

// File: tb/tb_hls_run_sequencer.sv
// tb_hls_run_sequencer: directed checks of memory access, runs, timeouts and reset abort.
module tb_hls_run_sequencer;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = '0;
   logic [6:0]  cmd_addr = '0;
   logic [7:0]  cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [7:0]  rsp_rdata;
   logic [1:0]  rsp_status;
   logic [31:0] run_cycles;
   logic        busy;
   logic        start_port;
   logic        done_port = 1'b0;
   logic [1:0]  S_oe_ram, S_we_ram;
   logic [13:0] S_addr_ram;
   logic [15:0] S_Wdata_ram;
   logic [7:0]  S_data_ram_size;
   logic [15:0] Sout_Rdata_ram = '0;
   logic [1:0]  Sout_DataRdy = '0;
   int          n_assert = 0;
   int          n_fail = 0;
   int          n;
   int          starts;

   hls_run_sequencer #(.RUN_TIMEOUT(50)) dut (
      .clock           (clock),
      .reset           (reset),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_addr        (cmd_addr),
      .cmd_wdata       (cmd_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_rdata       (rsp_rdata),
      .rsp_status      (rsp_status),
      .run_cycles      (run_cycles),
      .busy            (busy),
      .start_port      (start_port),
      .done_port       (done_port),
      .S_oe_ram        (S_oe_ram),
      .S_we_ram        (S_we_ram),
      .S_addr_ram      (S_addr_ram),
      .S_Wdata_ram     (S_Wdata_ram),
      .S_data_ram_size (S_data_ram_size),
      .Sout_Rdata_ram  (Sout_Rdata_ram),
      .Sout_DataRdy    (Sout_DataRdy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [6:0] a, input logic [7:0] d);
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_wdata = d;
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < 2000) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic finish_rsp(input string tag);
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
      chk(tag, {29'd0, busy, cmd_ready, rsp_valid}, 32'b010);
   endtask

   initial begin
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_ready_busy_valid", {29'd0, cmd_ready, busy, rsp_valid}, 32'b100);
      chk("rst_run_cycles", run_cycles, 32'd0);
      chk("rst_slave", {S_oe_ram, S_we_ram, S_data_ram_size, start_port}, 32'd0);

      // WRITE 0x05 <- 0xA5, DataRdy two cycles after the write strobe
      send(2'd0, 7'h05, 8'hA5);
      chk("wr_we", S_we_ram, 32'b01);
      chk("wr_oe", S_oe_ram, 32'b00);
      chk("wr_addr", S_addr_ram, 32'h0005);
      chk("wr_data", S_Wdata_ram, 32'h00A5);
      chk("wr_size", S_data_ram_size, 32'h08);
      chk("wr_ready_busy", {cmd_ready, busy}, 32'b01);
      @(negedge clock);
      chk("wr_we_one_cycle", {S_we_ram, S_addr_ram}, 32'd0);
      @(negedge clock);
      Sout_DataRdy   = 2'b01;
      Sout_Rdata_ram = 16'hFF77;
      @(negedge clock);
      Sout_DataRdy = 2'b00;
      chk("wr_rsp_valid", rsp_valid, 32'd1);
      chk("wr_rsp_status", rsp_status, 32'd0);
      chk("wr_rsp_rdata", rsp_rdata, 32'd0);
      finish_rsp("wr_back_idle");

      // READ 0x05 with DataRdy already high in the request cycle
      send(2'd1, 7'h05, 8'h00);
      chk("rd_oe", S_oe_ram, 32'b01);
      chk("rd_we", S_we_ram, 32'b00);
      chk("rd_addr", S_addr_ram, 32'h0005);
      Sout_DataRdy   = 2'b01;
      Sout_Rdata_ram = 16'h993C;
      @(negedge clock);
      Sout_DataRdy   = 2'b00;
      Sout_Rdata_ram = 16'h0000;
      chk("rd_rsp_valid", rsp_valid, 32'd1);
      chk("rd_rsp_rdata", rsp_rdata, 32'h3C);
      chk("rd_rsp_status", rsp_status, 32'd0);
      @(negedge clock);
      chk("rd_rsp_hold", {rsp_valid, rsp_rdata}, 32'h13C);
      finish_rsp("rd_back_idle");

      // RUN with done 10 cycles after the start pulse
      send(2'd2, 7'h00, 8'h00);
      starts = int'(start_port);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         starts += int'(start_port);
         if (k == 10) done_port = 1'b1;
      end
      @(negedge clock);
      done_port = 1'b0;
      chk("run_start_pulses", starts, 32'd1);
      chk("run_rsp_valid", rsp_valid, 32'd1);
      chk("run_cycles_11", run_cycles, 32'd11);
      chk("run_status", rsp_status, 32'd0);
      finish_rsp("run_back_idle");

      // done already high in START is ignored; first RUN cycle gives the minimum of 2
      send(2'd2, 7'h00, 8'h00);
      chk("min_start", start_port, 32'd1);
      done_port = 1'b1;
      @(negedge clock);
      chk("min_in_run", {start_port, rsp_valid, busy}, 32'b001);
      @(negedge clock);
      done_port = 1'b0;
      chk("min_rsp_valid", rsp_valid, 32'd1);
      chk("min_run_cycles", run_cycles, 32'd2);
      finish_rsp("min_back_idle");

      // READ with no DataRdy: 256 wait cycles then MEM_TIMEOUT
      send(2'd1, 7'h11, 8'h00);
      wait_rsp(n);
      chk("mto_latency", n, 32'd257);
      chk("mto_status", rsp_status, 32'd1);
      chk("mto_rdata", rsp_rdata, 32'd0);
      chk("mto_run_cycles_held", run_cycles, 32'd2);
      finish_rsp("mto_back_idle");

      // reserved op
      send(2'd3, 7'h00, 8'h00);
      chk("bad_valid_status", {rsp_valid, rsp_status}, 32'b111);
      chk("bad_no_slave", {S_oe_ram, S_we_ram}, 32'd0);
      finish_rsp("bad_back_idle");

      // reset mid-RUN aborts without a response
      send(2'd2, 7'h00, 8'h00);
      @(negedge clock);
      @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("abort_async", {28'd0, busy, cmd_ready, rsp_valid, start_port}, 32'b0100);
      chk("abort_run_cycles", run_cycles, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("abort_no_rsp", {busy, rsp_valid}, 32'b00);
      end

      // second run, response held with rsp_ready low for 5 cycles
      send(2'd2, 7'h00, 8'h00);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         if (k == 3) done_port = 1'b1;
      end
      @(negedge clock);
      done_port = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("hold_rsp", {rsp_valid, rsp_status, rsp_rdata, run_cycles[7:0]}, {21'd0, 1'b1, 2'd0, 8'd0, 8'd4});
         @(negedge clock);
      end
      finish_rsp("hold_back_idle");

`ifdef HLS_RUN_TIMEOUT_EN
      send(2'd2, 7'h00, 8'h00);
      wait_rsp(n);
      chk("rto_latency", n, 32'd50);
      chk("rto_status", rsp_status, 32'd2);
      chk("rto_run_cycles", run_cycles, 32'd50);
      finish_rsp("rto_back_idle");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
